// File: rtl/genie_mux_pkg.sv
// Shared definitions for the genie mux family.
package genie_mux_pkg;

  // Ceiling log2. Returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

  // Beat template: generated code re-declares this with its own data width.
  localparam int MUX_BEAT_W = 8;

  typedef struct packed {
    logic                  err;
    logic [MUX_BEAT_W-1:0] data;
  } mux_beat_t;

endpackage

// File: rtl/genie_pipe_stage.sv
// One elastic register slice: holds a single beat and passes ready upstream
// combinationally, so a full chain still moves one beat per cycle.
module genie_pipe_stage #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         vld_p;
  logic [W-1:0] dat_p;
  logic         load;

  // The slot can take a new beat when it is empty or its beat is leaving.
  assign load    = !vld_p || i_ready;
  assign o_ready = load;
  assign o_valid = vld_p;
  assign o_data  = dat_p;

  // Capture the upstream beat; a bubble only clears valid and keeps the data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_p <= 1'b0;
      dat_p <= '0;
    end else if (load) begin
      vld_p <= i_valid;
      if (i_valid) dat_p <= i_data;
    end
  end

endmodule

// File: rtl/genie_mux_pipe.sv
// Pipelined N:1 word multiplexer with valid/ready on both sides. Out-of-range
// selects forward a zero word flagged with o_err.
module genie_mux_pipe
  import genie_mux_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int SIZE      = 4,
  parameter int SEL_WIDTH = 2,
  parameter int PIPELINE  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [WIDTH*SIZE-1:0] i_data,
  input  logic [SEL_WIDTH-1:0]  i_sel,
  input  logic                  i_valid,
  output logic                  o_ready,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_err,
  output logic                  o_valid,
  input  logic                  i_ready
);

  typedef struct packed {
    logic             err;
    logic [WIDTH-1:0] data;
  } beat_t;

  logic [SIZE-1:0] hot;
  beat_t           mux_beat;

  // One-hot decode of the select followed by an AND-OR mux; the extra
  // compare bit keeps SIZE itself representable so the range test never wraps.
  always_comb begin
    hot      = '0;
    mux_beat = '0;
    for (int k = 0; k < SIZE; k++) begin
      hot[k] = ({1'b0, i_sel} == (SEL_WIDTH+1)'(k));
    end
    mux_beat.err = ({1'b0, i_sel} >= (SEL_WIDTH+1)'(SIZE));
    for (int k = 0; k < SIZE; k++) begin
      mux_beat.data = mux_beat.data | (i_data[k*WIDTH +: WIDTH] & {WIDTH{hot[k]}});
    end
  end

  if (PIPELINE == 0) begin : g_comb
    // No state: the block is a plain combinational select.
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ reset;
    assign o_data  = mux_beat.data;
    assign o_err   = mux_beat.err;
    assign o_valid = i_valid;
    assign o_ready = i_ready;
  end else begin : g_pipe
    for (genvar s = 0; s < PIPELINE; s++) begin : g_stg
      logic             vld_in;
      logic [WIDTH:0]   dat_in;
      logic             rdy_up;
      logic             rdy_dn;
      logic             vld_p;
      logic [WIDTH:0]   dat_p;

      // ---- stage boundary: stage s takes from stage s-1 (or the mux) ----
      if (s == 0) begin : g_head
        assign vld_in = i_valid;
        assign dat_in = mux_beat;
      end else begin : g_body
        assign vld_in = g_stg[s-1].vld_p;
        assign dat_in = g_stg[s-1].dat_p;
      end

      if (s == PIPELINE-1) begin : g_tail
        assign rdy_dn = i_ready;
      end else begin : g_mid
        assign rdy_dn = g_stg[s+1].rdy_up;
      end

      genie_pipe_stage #(
        .W (WIDTH+1)
      ) u_stage (
        .clk     (clk),
        .reset   (reset),
        .i_valid (vld_in),
        .o_ready (rdy_up),
        .i_data  (dat_in),
        .o_valid (vld_p),
        .i_ready (rdy_dn),
        .o_data  (dat_p)
      );
    end

    assign o_ready = g_stg[0].rdy_up;
    assign o_valid = g_stg[PIPELINE-1].vld_p;
    assign o_err   = g_stg[PIPELINE-1].dat_p[WIDTH];
    assign o_data  = g_stg[PIPELINE-1].dat_p[WIDTH-1:0];
  end

endmodule
